// File: rtl/string_search_ctrl.sv
// Purpose : naive backtracking pattern search over a synchronous-read text memory.
// Latency : 2 cycles per symbol comparison (FETCH + COMPARE); done pulses 2N+1 cycles after start, 1 for degenerate starts.
// Backpress: none; start is only accepted in IDLE, pattern writes only while not busy.
//
// Optional feature macro: FIND_ALL_EN
//   defined   -> keep scanning after a match, counting every (overlapping) occurrence.
//   undefined -> stop at the first match (match_count <= 1).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pat_wr_en/idx/data      pattern register file write port (ignored while busy)
//   pat_len, text_len       search lengths, sampled when start is accepted
//   start                   launch a search (accepted only in IDLE)
//   read_addr, mem_rdata    text memory read port (data returns one cycle after address)
//   busy, done              search in progress / one-cycle completion pulse
//   found, match_addr       at least one match / start address of the first match
//   match_count             number of matches found
module string_search_ctrl #(
  parameter int DEPTH   = 64,
  parameter int LENGTH  = 8,
  parameter int ADDR_W  = 6,
  parameter int PAT_MAX = 8,
  localparam int IDX_W  = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1,
  localparam int PL_W   = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pat_wr_en,
  input  logic [IDX_W-1:0]  pat_wr_idx,
  input  logic [LENGTH-1:0] pat_wr_data,
  input  logic [PL_W-1:0]   pat_len,
  input  logic [ADDR_W:0]   text_len,
  input  logic              start,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [LENGTH-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] match_addr,
  output logic [ADDR_W:0]   match_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] TL_MAX = (ADDR_W + 1)'(DEPTH);

  state_t              r_state,       w_state_nxt;
  logic [ADDR_W-1:0]   r_i,           w_i_nxt;
  logic [IDX_W-1:0]    r_j,           w_j_nxt;
  logic [PL_W-1:0]     r_pat_len,     w_pat_len_nxt;
  logic [ADDR_W:0]     r_last,        w_last_nxt;
  logic [ADDR_W-1:0]   r_read_addr,   w_read_addr_nxt;
  logic                r_found,       w_found_nxt;
  logic [ADDR_W-1:0]   r_match_addr,  w_match_addr_nxt;
  logic [ADDR_W:0]     r_match_count, w_match_count_nxt;

  // Pattern storage deliberately has no reset: it survives a search abort.
  logic [LENGTH-1:0]   r_pat [PAT_MAX];

  logic [ADDR_W:0]     w_text_len;
  logic [ADDR_W:0]     w_pat_len_ext;
  logic                w_degen;
  logic                w_at_last;
  logic                w_last_j;
  logic                w_sym_eq;

  // Text beyond the memory does not exist, so clamp the requested length.
  assign w_text_len    = (text_len > TL_MAX) ? TL_MAX : text_len;
  assign w_pat_len_ext = (ADDR_W + 1)'(pat_len);
  assign w_degen       = (pat_len == '0) ||
                         (pat_len > PL_W'(PAT_MAX)) ||
                         (w_pat_len_ext > w_text_len);

  // i never exceeds last, so "i < last" is simply "not at last".
  assign w_at_last = ({1'b0, r_i} == r_last);
  assign w_last_j  = ({1'b0, r_j} == (r_pat_len - 1'b1));
  assign w_sym_eq  = (mem_rdata == r_pat[r_j]);

  assign busy        = (r_state == S_FETCH) || (r_state == S_COMPARE);
  assign done        = (r_state == S_DONE);
  assign read_addr   = r_read_addr;
  assign found       = r_found;
  assign match_addr  = r_match_addr;
  assign match_count = r_match_count;

  // Pattern register file write port.
  always_ff @(posedge clk) begin
    if (pat_wr_en && !busy && (int'(pat_wr_idx) < PAT_MAX)) begin
      r_pat[pat_wr_idx] <= pat_wr_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_i           <= '0;
      r_j           <= '0;
      r_pat_len     <= '0;
      r_last        <= '0;
      r_read_addr   <= '0;
      r_found       <= 1'b0;
      r_match_addr  <= '0;
      r_match_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_i           <= w_i_nxt;
      r_j           <= w_j_nxt;
      r_pat_len     <= w_pat_len_nxt;
      r_last        <= w_last_nxt;
      r_read_addr   <= w_read_addr_nxt;
      r_found       <= w_found_nxt;
      r_match_addr  <= w_match_addr_nxt;
      r_match_count <= w_match_count_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt       = r_state;
    w_i_nxt           = r_i;
    w_j_nxt           = r_j;
    w_pat_len_nxt     = r_pat_len;
    w_last_nxt        = r_last;
    w_read_addr_nxt   = r_read_addr;
    w_found_nxt       = r_found;
    w_match_addr_nxt  = r_match_addr;
    w_match_count_nxt = r_match_count;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pat_len_nxt     = pat_len;
          w_last_nxt        = w_text_len - w_pat_len_ext;
          w_found_nxt       = 1'b0;
          w_match_addr_nxt  = '0;
          w_match_count_nxt = '0;
          if (w_degen) begin
            w_state_nxt = S_DONE;
          end else begin
            w_i_nxt     = '0;
            w_j_nxt     = '0;
            w_state_nxt = S_FETCH;
          end
        end
      end

      // Address was already registered on entry, so the memory samples it
      // at the end of this cycle and data is valid during COMPARE.
      S_FETCH: begin
        w_state_nxt = S_COMPARE;
      end

      S_COMPARE: begin
        if (w_sym_eq) begin
          if (!w_last_j) begin
            w_j_nxt     = r_j + 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            if (!r_found) begin
              w_found_nxt      = 1'b1;
              w_match_addr_nxt = r_i;
            end
            w_match_count_nxt = r_match_count + 1'b1;
`ifdef FIND_ALL_EN
            if (!w_at_last) begin
              w_i_nxt     = r_i + 1'b1;
              w_j_nxt     = '0;
              w_state_nxt = S_FETCH;
            end else begin
              w_state_nxt = S_DONE;
            end
`else
            w_state_nxt = S_DONE;
`endif
          end
        end else if (w_at_last) begin
          w_state_nxt = S_DONE;
        end else begin
          // Backtrack: restart the pattern at the next candidate position.
          w_i_nxt     = r_i + 1'b1;
          w_j_nxt     = '0;
          w_state_nxt = S_FETCH;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Register the memory address as FETCH is entered so it is stable
    // for the whole FETCH cycle.
    if (w_state_nxt == S_FETCH) begin
      w_read_addr_nxt = w_i_nxt + ADDR_W'(w_j_nxt);
    end
  end

endmodule

// File: tb/tb_string_search_ctrl.sv
// Purpose : scoreboard bench for string_search_ctrl with a synchronous text memory model.
// Latency : expected done latency is carried in each scoreboard entry and checked by the monitor.
// Backpress: n/a; stimulus waits for the scoreboard to drain under a cycle budget.
module tb_string_search_ctrl;

  localparam int DEPTH   = 64;
  localparam int LENGTH  = 8;
  localparam int ADDR_W  = 6;
  localparam int PAT_MAX = 8;
  localparam int IDX_W   = 3;
  localparam int PL_W    = 4;

`ifdef FIND_ALL_EN
  localparam bit FA = 1'b1;
`else
  localparam bit FA = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pat_wr_en = 1'b0;
  logic [IDX_W-1:0]  pat_wr_idx = '0;
  logic [LENGTH-1:0] pat_wr_data = '0;
  logic [PL_W-1:0]   pat_len = '0;
  logic [ADDR_W:0]   text_len = '0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] read_addr;
  logic [LENGTH-1:0] mem_rdata = '0;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] match_addr;
  logic [ADDR_W:0]   match_count;

  string_search_ctrl #(
    .DEPTH(DEPTH), .LENGTH(LENGTH), .ADDR_W(ADDR_W), .PAT_MAX(PAT_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pat_wr_en(pat_wr_en), .pat_wr_idx(pat_wr_idx), .pat_wr_data(pat_wr_data),
    .pat_len(pat_len), .text_len(text_len), .start(start),
    .read_addr(read_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .found(found),
    .match_addr(match_addr), .match_count(match_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read text memory.
  logic [LENGTH-1:0] text_mem [DEPTH];
  always @(posedge clk) mem_rdata <= text_mem[read_addr];

  typedef struct packed {
    logic        found;
    logic [5:0]  addr;
    logic [6:0]  cnt;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: remembers when an accepted start was seen, checks results on done.
  always @(negedge clk) begin
    if (rst_n && start && !busy && !done) start_cyc = cyc;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending search (t=%0t)", $time);
      end else begin
        m_e = sb.pop_front();
        check("found",       32'(found),       32'(m_e.found));
        check("match_addr",  32'(match_addr),  32'(m_e.addr));
        check("match_count", 32'(match_count), 32'(m_e.cnt));
        check("latency",     32'(cyc - start_cyc), m_e.lat);
      end
    end
  end

  task automatic load_text(input logic [7:0] v[], input int n);
    for (int k = 0; k < DEPTH; k++) text_mem[k] = 8'hFF;
    for (int k = 0; k < n; k++) text_mem[k] = v[k];
  endtask

  task automatic load_pat(input logic [7:0] v[], input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      pat_wr_en   = 1'b1;
      pat_wr_idx  = IDX_W'(k);
      pat_wr_data = v[k];
    end
    @(posedge clk); #1;
    pat_wr_en = 1'b0;
  endtask

  task automatic issue(input int tl, input int pl, input bit push,
                       input bit ef, input int ea, input int ec, input int el);
    exp_t e;
    @(posedge clk); #1;
    text_len = 7'(tl);
    pat_len  = 4'(pl);
    start    = 1'b1;
    e.found = ef; e.addr = 6'(ea); e.cnt = 7'(ec); e.lat = 32'(el);
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_sb(input string name);
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  logic [7:0] txt_a [] = '{8'd2, 8'd3, 8'd4, 8'd8, 8'd23, 8'd10, 8'd11, 8'd12, 8'd24};
  logic [7:0] txt_b [] = '{8'd5, 8'd5, 8'd5, 8'd5};
  logic [7:0] pat_1 [] = '{8'd8, 8'd23, 8'd10};
  logic [7:0] pat_2 [] = '{8'd8, 8'd23, 8'd11};
  logic [7:0] pat_3 [] = '{8'd5, 8'd5};
  logic [7:0] pat_4 [] = '{8'd11, 8'd12, 8'd24};

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int saved_done;
    for (int k = 0; k < DEPTH; k++) text_mem[k] = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_addr",   32'(read_addr),   0);
    check("rst_busy",        32'(busy),        0);
    check("rst_done",        32'(done),        0);
    check("rst_found",       32'(found),       0);
    check("rst_match_addr",  32'(match_addr),  0);
    check("rst_match_count", 32'(match_count), 0);
    rst_n = 1'b1;

    // First occurrence in the middle of the text.
    load_text(txt_a, 9);
    load_pat(pat_1, 3);
    issue(9, 3, 1, 1, 3, 1, FA ? 19 : 13);
    wait_sb("t1");

    // Overlapping occurrences.
    load_text(txt_b, 4);
    load_pat(pat_3, 2);
    issue(4, 2, 1, 1, 0, FA ? 3 : 1, FA ? 13 : 5);
    wait_sb("t3");

    // Match at the last candidate position.
    load_text(txt_a, 9);
    load_pat(pat_4, 3);
    issue(9, 3, 1, 1, 6, 1, 19);
    wait_sb("t5");

    // No match: partial match at i=3, ends after i=6 is checked.
    load_pat(pat_2, 3);
    issue(9, 3, 1, 0, 0, 0, 19);
    wait_sb("t2");
    check("nomatch_read_addr", 32'(read_addr), 6);

    // Degenerate starts: no reads, done next cycle, read_addr held at 6.
    issue(9, 0, 1, 0, 0, 0, 1);
    wait_sb("deg0");
    check("deg0_read_addr", 32'(read_addr), 6);
    issue(4, 5, 1, 0, 0, 0, 1);
    wait_sb("deg_long");
    check("deg_long_read_addr", 32'(read_addr), 6);
    issue(9, 9, 1, 0, 0, 0, 1);
    wait_sb("deg_max");
    check("deg_max_read_addr", 32'(read_addr), 6);

    // Restart while busy and pattern write while busy are both ignored.
    load_pat(pat_1, 3);
    issue(9, 3, 1, 1, 3, 1, FA ? 19 : 13);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; pat_len = 4'd0;
    pat_wr_en = 1'b1; pat_wr_idx = 3'd1; pat_wr_data = 8'd99;
    @(posedge clk); #1;
    start = 1'b0; pat_wr_en = 1'b0;
    wait_sb("busy_ignore");
    issue(9, 3, 1, 1, 3, 1, FA ? 19 : 13);
    wait_sb("pat_kept");

    // Asynchronous reset mid-search.
    saved_done = done_cnt;
    issue(9, 3, 0, 0, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("arst_read_addr",   32'(read_addr),   0);
    check("arst_busy",        32'(busy),        0);
    check("arst_done",        32'(done),        0);
    check("arst_found",       32'(found),       0);
    check("arst_match_addr",  32'(match_addr),  0);
    check("arst_match_count", 32'(match_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("arst_no_done", 32'(done_cnt), 32'(saved_done));

    // Pattern survives reset.
    issue(9, 3, 1, 1, 3, 1, FA ? 19 : 13);
    wait_sb("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/string_search_ctrl.md
# string_search_ctrl

Sequential pattern-search engine that sits directly downstream of the text memory (`Memory_with_read_addr`). After `start`, it drives the memory's `read_addr`, consumes `dataout`, and compares the stored text against a locally held pattern of up to `PAT_MAX` symbols. It reports whether the pattern occurs, the address of the first occurrence, and, when configured, the total occurrence count.

## Interface
Parameters:
- `DEPTH`, 64: text memory depth in symbols.
- `LENGTH`, 8: symbol width in bits; matches the memory data width.
- `ADDR_W`, 6: memory address width; equals log2(`DEPTH`).
- `PAT_MAX`, 8: maximum pattern length in symbols.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pat_wr_en`  in  1  write one pattern symbol.
- `pat_wr_idx`  in  clog2(`PAT_MAX`)  pattern slot index.
- `pat_wr_data`  in  `LENGTH`  pattern symbol.
- `pat_len`  in  clog2(`PAT_MAX`)+1  pattern length; sampled at start.
- `text_len`  in  `ADDR_W`+1  number of valid text symbols at addresses 0..`text_len`-1; sampled at start.
- `start`  in  1  launch a search.
- `read_addr`  out  `ADDR_W`  memory read address.
- `mem_rdata`  in  `LENGTH`  memory `dataout`. It is valid one cycle after `read_addr`, because the memory read is synchronous.
- `busy`  out  1  search in progress.
- `done`  out  1  one-cycle completion pulse.
- `found`  out  1  at least one match.
- `match_addr`  out  `ADDR_W`  start address of the first match.
- `match_count`  out  `ADDR_W`+1  number of matches.

## Operation
- The pattern register file holds `PAT_MAX` entries of `LENGTH` bits.
  - A write with `pat_wr_en`=1 while `busy`=0 updates slot `pat_wr_idx`.
  - Writes while `busy`=1 are ignored.
  - The register file is not cleared by reset.
- Internal counters:
  - `i`: candidate start position.
  - `j`: pattern offset.
  - `last` = `text_len` − `pat_len`, latched at start.
- FSM states:
  - **IDLE:** when `start`=1, the block latches the lengths and clears `found`, `match_addr` and `match_count`.
    - If `pat_len`=0, `pat_len` > `PAT_MAX`, or `pat_len` > `text_len`, it goes to DONE with no memory reads.
    - Otherwise it sets `i`=0, `j`=0 and goes to FETCH.
  - **FETCH:** drives `read_addr` = `i`+`j`, then goes to COMPARE.
  - **COMPARE:** compares `mem_rdata` with `pat[j]`.
    - Equal and `j` < `pat_len`−1: `j`++ and go to FETCH.
    - Equal and `j` = `pat_len`−1: this is a match (see match handling below).
    - Not equal: if `i` = `last`, go to DONE; otherwise `i`++, `j`=0 and go to FETCH.
  - **DONE:** `done`=1 for exactly one cycle, then IDLE.
- Match handling:
  - On the first match, `found` is set and `match_addr` = `i`.
  - `match_count` increments on every match.
  - The next action after a match depends on configuration; see Configuration.
- Search style:
  - The search is naive and backtracking.
  - Overlapping matches are detected when FIND_ALL is enabled.
- Outputs while not searching:
  - `read_addr` holds its last value in IDLE and DONE.
  - `read_addr` is 0 after reset.
- Result hold and ignored inputs:
  - `found`, `match_addr` and `match_count` hold until the next accepted `start`.
  - `start` is ignored while `busy`=1.
  - `busy` is 1 in FETCH and COMPARE, and 0 in IDLE and DONE.

## Timing
- Reset values:
  - State IDLE.
  - `read_addr`=0, `busy`=0, `done`=0, `found`=0, `match_addr`=0, `match_count`=0.
- Every symbol comparison costs 2 cycles (FETCH, then COMPARE).
- If a search performs N comparisons, `done` is high in the cycle 2N+1 cycles after the edge that samples `start`.
- A degenerate start (zero-length pattern, or pattern longer than the text) gives `done` in the next cycle.
- Reset asserted mid-search aborts immediately to IDLE. No `done` pulse is produced, and all outputs return to their reset values.
- A `start` that coincides with the DONE cycle is ignored. The earliest accepted restart is the cycle after `done`.

## Configuration
- `FIND_ALL_EN` defined:
  - After a match, if `i` < `last`, the block sets `i`++, `j`=0 and continues scanning; otherwise it goes to DONE.
  - `match_count` counts every occurrence, including overlapping ones.
- `FIND_ALL_EN` undefined:
  - The first match goes straight to DONE.
  - `match_count` is at most 1.

## Test plan
- Text 2,3,4,8,23,10,11,12,24 (`text_len`=9); pattern 8,23,10 (`pat_len`=3); `FIND_ALL_EN` undefined. Required: N=6, `done` 13 cycles after start, `found`=1, `match_addr`=3, `match_count`=1.
- Same case with `FIND_ALL_EN` defined. Required: N=9, `done` 19 cycles after start, `found`=1, `match_addr`=3, `match_count`=1.
- Text 5,5,5,5 (`text_len`=4); pattern 5,5; `FIND_ALL_EN` defined. Required: `match_count`=3 (overlapping), `match_addr`=0.
- Same text as the first case; pattern 8,23,11. Required: `found`=0, `match_count`=0, and `done` only after `i`=6 is checked.
- Degenerate starts: `pat_len`=0, or `pat_len`=5 with `text_len`=4. Required: `done` in the next cycle, `found`=0, `read_addr` unchanged.
- Robustness during a search. Required:
  - `rst_n` pulsed low mid-search: all outputs return to reset values at once and no `done` appears.
  - `start` re-pulsed while `busy`: ignored.
  - `pat_wr_en` while `busy`: the pattern is unchanged.
